add_tree_pipe: RTL

Parametrised, fully pipelined adder tree that sums NUM_INPUTS operands of WIDTH bits each. The output is full precision, so no overflow is lost. Every tree level is registered, and a valid/ready handshake with whole-pipeline stall lets the block sit in a streaming datapath behind a producer and in front of a backpressuring consumer. It supersedes the fixed 8-input, truncating adder tree in the timing examples.

---
 rtl/add_tree_pipe_pkg.sv | 35 +++
 rtl/add_tree_pipe_level.sv | 56 +++++
 rtl/add_tree_pipe.sv | 91 +++++++++
 3 files changed

// File: rtl/add_tree_pipe_pkg.sv
// add_tree_pipe_pkg: sizing helpers shared by the pipelined adder tree.
// The tree shape depends only on the operand count. A level halves the
// entry count (rounding up), and the sum grows one bit per level.
// Build option ADD_TREE_PIPE_SIGNED_EN (in the top) selects signed operands.
// It does not affect any sizing here.
package add_tree_pipe_pkg;

  // Number of pairwise-add levels after the input register (0 for n = 1).
  function automatic int level_count(input int n);
    return $clog2(n);
  endfunction

  // Entry count of level k (level 0 is the registered input set).
  function automatic int level_size(input int n, input int k);
    int s;
    s = n;
    for (int i = 0; i < k; i++) s = (s + 1) / 2;
    return s;
  endfunction

  // Entries held by levels 0..k-1. The top uses this to place every level
  // in one flat bus.
  function automatic int level_offset(input int n, input int k);
    int acc;
    acc = 0;
    for (int i = 0; i < k; i++) acc += level_size(n, i);
    return acc;
  endfunction

  // Full-precision output width: one carry bit per tree level.
  function automatic int sum_width(input int width, input int n);
    return width + level_count(n);
  endfunction

endpackage

// File: rtl/add_tree_pipe_level.sv
// add_tree_pipe_level: one registered pairwise-add level of the tree.
// Entry j of the output is in[2j] + in[2j+1]. An odd trailing entry is
// registered unchanged. Operands arrive already extended to SUM_WIDTH.
// For that reason the same modular add serves both signed and unsigned
// builds (ADD_TREE_PIPE_SIGNED_EN is handled in the top).
module add_tree_pipe_level
  import add_tree_pipe_pkg::*;
#(
  parameter int IN_COUNT  = 2,
  parameter int SUM_WIDTH = 17
)(
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic                                    in_vld,
  input  logic [IN_COUNT*SUM_WIDTH-1:0]           in_data,
  output logic                                    out_vld,
  output logic [((IN_COUNT+1)/2)*SUM_WIDTH-1:0]   out_data
);

  localparam int OUT_COUNT = (IN_COUNT + 1) / 2;

  // Exact within SUM_WIDTH: the tree never exceeds 2^LEVELS operands.
  function automatic logic [SUM_WIDTH-1:0] add_pair(input logic [SUM_WIDTH-1:0] a,
                                                     input logic [SUM_WIDTH-1:0] b);
    return a + b;
  endfunction

  logic [OUT_COUNT*SUM_WIDTH-1:0] nxt_p0;
  logic [OUT_COUNT*SUM_WIDTH-1:0] data_p1;
  logic                           vld_p1;

  for (genvar j = 0; j < OUT_COUNT; j++) begin : g_pair
    if (2 * j + 1 < IN_COUNT) begin : g_add
      assign nxt_p0[j*SUM_WIDTH +: SUM_WIDTH] =
        add_pair(in_data[(2*j)*SUM_WIDTH +: SUM_WIDTH], in_data[(2*j+1)*SUM_WIDTH +: SUM_WIDTH]);
    end else begin : g_pass
      assign nxt_p0[j*SUM_WIDTH +: SUM_WIDTH] = in_data[(2*j)*SUM_WIDTH +: SUM_WIDTH];
    end
  end

  // Level register: shifts on the global enable and freezes (bubbles included) on a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (en) begin
      data_p1 <= nxt_p0;
      vld_p1  <= in_vld;
    end
  end

  assign out_data = data_p1;
  assign out_vld  = vld_p1;

endmodule

// File: rtl/add_tree_pipe.sv
// add_tree_pipe: fully pipelined, full-precision adder tree of NUM_INPUTS
// operands with a valid/ready handshake. Any backpressure stalls the whole pipe.
// Latency is 1 + $clog2(NUM_INPUTS) edges from acceptance to out_valid.
// Build option: define ADD_TREE_PIPE_SIGNED_EN to treat operands as two's
// complement. The sum is then signed. Otherwise the operands are unsigned.
module add_tree_pipe
  import add_tree_pipe_pkg::*;
#(
  parameter  int NUM_INPUTS = 8,
  parameter  int WIDTH      = 16,
  localparam int LEVELS     = level_count(NUM_INPUTS),
  localparam int SUM_WIDTH  = sum_width(WIDTH, NUM_INPUTS)
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            inputs [NUM_INPUTS],
  output logic                        out_valid,
  input  logic                        out_ready,
`ifdef ADD_TREE_PIPE_SIGNED_EN
  output logic signed [SUM_WIDTH-1:0] sum
`else
  output logic [SUM_WIDTH-1:0]        sum
`endif
);

  // All levels live in one flat bus: level k starts at level_offset(N, k) entries.
  localparam int TOTAL_ENTRIES = level_offset(NUM_INPUTS, LEVELS + 1);
  localparam int OUT_BASE      = level_offset(NUM_INPUTS, LEVELS) * SUM_WIDTH;

  // Widen one operand to the full output width.
  function automatic logic [SUM_WIDTH-1:0] extend(input logic [WIDTH-1:0] x);
`ifdef ADD_TREE_PIPE_SIGNED_EN
    logic signed [WIDTH-1:0] xs;
    xs = signed'(x);
    return SUM_WIDTH'(xs);
`else
    return SUM_WIDTH'(x);
`endif
  endfunction

  logic                                en;
  logic [NUM_INPUTS*SUM_WIDTH-1:0]     data_p0;
  logic                                vld_p0;
  logic [TOTAL_ENTRIES*SUM_WIDTH-1:0]  data_flat;
  logic [LEVELS:0]                     vld_chain;

  // A stalled output blocks everything. There is no path from in_valid to in_ready.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 0: register the extended operand set alongside its valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < NUM_INPUTS; i++) data_p0[i*SUM_WIDTH +: SUM_WIDTH] <= extend(inputs[i]);
      vld_p0 <= in_valid;
    end
  end

  assign data_flat[NUM_INPUTS*SUM_WIDTH-1:0] = data_p0;
  assign vld_chain[0]                        = vld_p0;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int IN_COUNT  = level_size(NUM_INPUTS, k - 1);
    localparam int OUT_COUNT = level_size(NUM_INPUTS, k);
    localparam int IN_BASE   = level_offset(NUM_INPUTS, k - 1) * SUM_WIDTH;
    localparam int OUT_LO    = level_offset(NUM_INPUTS, k) * SUM_WIDTH;

    add_tree_pipe_level #(
      .IN_COUNT  (IN_COUNT),
      .SUM_WIDTH (SUM_WIDTH)
    ) u_level (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_vld   (vld_chain[k-1]),
      .in_data  (data_flat[IN_BASE +: IN_COUNT*SUM_WIDTH]),
      .out_vld  (vld_chain[k]),
      .out_data (data_flat[OUT_LO +: OUT_COUNT*SUM_WIDTH])
    );
  end

  // The single register of the last level is the output itself.
  assign out_valid = vld_chain[LEVELS];
  assign sum       = data_flat[OUT_BASE +: SUM_WIDTH];

endmodule
